uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one uarttx transmitter core between NREQ byte requesters.
- Accepts one byte from the winning requester and drives the core's newd/tx_data pair for long enough that the slow UART clock samples it.
- Waits for the core's donetx, then reports completion to the owning requester.
- Sits between producer blocks (command/status formatters) and the uarttx instance, in the same clk domain.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter view; master is the requesters plus uarttx core view.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_done;
    logic              newd;
    logic [7:0]        tx_data;
    logic              donetx;
    logic              busy;
    logic [2:0]        grant_id;
    logic              err;

    modport slave (
        input  req_valid, req_data, donetx,
        output req_ready, req_done, newd, tx_data, busy, grant_id, err
    );

    modport master (
        output req_valid, req_data, donetx,
        input  req_ready, req_done, newd, tx_data, busy, grant_id, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx core between NREQ byte requesters.
// Optional WAIT_DONE timeout with sticky err is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned HOLD_CYCLES    = 110,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave arb_io
);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitDone, StRelease} state_e;

    state_e            state_q;
    logic              newd_q;
    logic [7:0]        tx_data_q;
    logic [NREQ-1:0]   req_ready_q;
    logic [NREQ-1:0]   req_done_q;
    logic [2:0]        grant_q;
    logic [HoldW-1:0]  hold_q;
    logic              donetx_q;
    logic              done_edge;

    logic              hi_found;
    logic              any_valid;
    logic [2:0]        hi_idx;
    logic [2:0]        lo_idx;
    logic [2:0]        win_idx;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found  = 1'b0;
        any_valid = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (arb_io.req_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = 3'(i);
                if (i > int'(grant_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    assign done_edge = arb_io.donetx & ~donetx_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q;
    logic            err_q;
    assign arb_io.err = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign arb_io.err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            newd_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            req_ready_q <= '0;
            req_done_q  <= '0;
            grant_q     <= 3'(NREQ - 1);
            hold_q      <= '0;
            donetx_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            donetx_q    <= arb_io.donetx;
            req_ready_q <= '0;
            req_done_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        req_ready_q <= NREQ'(1) << win_idx;
                        tx_data_q   <= arb_io.req_data[8*win_idx +: 8];
                        grant_q     <= win_idx;
                        newd_q      <= 1'b1;
                        hold_q      <= '0;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
                        newd_q  <= 1'b0;
                        state_q <= StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (done_edge) begin
                        state_q <= StRelease;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StRelease;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                StRelease: begin
                    req_done_q <= NREQ'(1) << grant_q;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign arb_io.req_ready = req_ready_q;
    assign arb_io.req_done  = req_done_q;
    assign arb_io.newd      = newd_q;
    assign arb_io.tx_data   = tx_data_q;
    assign arb_io.grant_id  = grant_q;
    assign arb_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of grants plus reset/timeout sequences.
// Timeout sequence compiles in only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 110;
    localparam int unsigned TMO  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) arb_if ();

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .arb_io(arb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [2:0]  exp_grant;
        logic [7:0]  exp_byte;
        logic [3:0]  valid_after;
        logic [31:0] data_after;
        logic        glitch;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v);
        int   n;
        logic [3:0] onehot;
        onehot = 4'b0001 << v.exp_grant;
        arb_if.req_valid = v.valid;
        arb_if.req_data  = v.data;
        n = 0;
        while (arb_if.req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check("req_ready", 32'(arb_if.req_ready), 32'(onehot));
        check("tx_data_accept", 32'(arb_if.tx_data), 32'(v.exp_byte));
        check("grant_id", 32'(arb_if.grant_id), 32'(v.exp_grant));
        check("newd_rise", 32'(arb_if.newd), 32'd1);
        check("req_done_at_accept", 32'(arb_if.req_done), 32'd0);
        arb_if.req_valid = v.valid_after;
        arb_if.req_data  = v.data_after;
        n = 0;
        while (arb_if.newd && n < 300) begin
            if (v.glitch && n == 10) arb_if.donetx = 1'b1;
            if (v.glitch && n == 12) arb_if.donetx = 1'b0;
            n++;
            tick();
        end
        check("newd_hold_len", 32'(n), 32'(HOLD));
        check("tx_data_latched", 32'(arb_if.tx_data), 32'(v.exp_byte));
        for (int i = 0; i < 3; i++) tick();
        check("no_early_done", 32'(arb_if.req_done), 32'd0);
        check("busy_wait", 32'(arb_if.busy), 32'd1);
        arb_if.donetx = 1'b1;
        tick();
        check("done_latency1", 32'(arb_if.req_done), 32'd0);
        tick();
        check("req_done", 32'(arb_if.req_done), 32'(onehot));
        check("busy_fall", 32'(arb_if.busy), 32'd0);
        check("no_ready_with_done", 32'(arb_if.req_ready), 32'd0);
        arb_if.donetx = 1'b0;
        tick();
        check("done_single", 32'(arb_if.req_done), 32'd0);
    endtask

    initial begin
        int   n;
        int   dones;
        vec_t v;
        vecs[0] = '{4'b1111, 32'h43322110, 3'd0, 8'h10, 4'b1111, 32'h43322110, 1'b0};
        vecs[1] = '{4'b1111, 32'h43322110, 3'd1, 8'h21, 4'b1111, 32'h43322110, 1'b0};
        vecs[2] = '{4'b1111, 32'h43322110, 3'd2, 8'h32, 4'b1111, 32'h43322110, 1'b0};
        vecs[3] = '{4'b1111, 32'h43322110, 3'd3, 8'h43, 4'b1111, 32'h43322110, 1'b0};
        vecs[4] = '{4'b1111, 32'h43322110, 3'd0, 8'h10, 4'b0000, 32'h43322110, 1'b0};
        vecs[5] = '{4'b0001, 32'h000000A5, 3'd0, 8'hA5, 4'b0000, 32'h000000A5, 1'b1};
        vecs[6] = '{4'b0100, 32'h00770000, 3'd2, 8'h77, 4'b0000, 32'h00770000, 1'b0};
        vecs[7] = '{4'b0101, 32'h00880099, 3'd0, 8'h99, 4'b0101, 32'h00880099, 1'b0};
        vecs[8] = '{4'b0101, 32'h00880099, 3'd2, 8'h88, 4'b0000, 32'h00880099, 1'b0};
        vecs[9] = '{4'b0010, 32'h00003C00, 3'd1, 8'h3C, 4'b0000, 32'h0000FF00, 1'b0};

        arb_if.req_valid = '0;
        arb_if.req_data  = '0;
        arb_if.donetx    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_newd", 32'(arb_if.newd), 32'd0);
        check("rst_tx_data", 32'(arb_if.tx_data), 32'd0);
        check("rst_req_ready", 32'(arb_if.req_ready), 32'd0);
        check("rst_req_done", 32'(arb_if.req_done), 32'd0);
        check("rst_busy", 32'(arb_if.busy), 32'd0);
        check("rst_grant_id", 32'(arb_if.grant_id), 32'(NREQ - 1));
        check("rst_err", 32'(arb_if.err), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("idle_no_grant", 32'(arb_if.req_ready), 32'd0);
        check("idle_busy", 32'(arb_if.busy), 32'd0);

        for (int i = 0; i < 10; i++) do_xfer(vecs[i]);

        // Reset in the middle of LOAD must abort the frame silently.
        arb_if.req_valid = 4'b1000;
        arb_if.req_data  = 32'h5A000000;
        n = 0;
        while (arb_if.req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check("rst_seq_ready", 32'(arb_if.req_ready), 32'b1000);
        arb_if.req_valid = '0;
        for (int i = 0; i < 20; i++) tick();
        check("rst_seq_newd_high", 32'(arb_if.newd), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_newd", 32'(arb_if.newd), 32'd0);
        check("midrst_busy", 32'(arb_if.busy), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        check("midrst_grant_id", 32'(arb_if.grant_id), 32'(NREQ - 1));
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (arb_if.req_done != '0 || arb_if.newd) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        v = '{4'b0010, 32'h00006600, 3'd1, 8'h66, 4'b0000, 32'h00006600, 1'b0};
        do_xfer(v);

`ifdef UART_ARB_TIMEOUT_EN
        arb_if.req_valid = 4'b0001;
        arb_if.req_data  = 32'h000000E7;
        n = 0;
        while (arb_if.req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check("tmo_ready", 32'(arb_if.req_ready), 32'b0001);
        arb_if.req_valid = '0;
        n = 0;
        while (!arb_if.err && n < HOLD + TMO + 50) begin
            tick();
            n++;
        end
        check("tmo_err_latency", 32'(n), 32'(HOLD + TMO));
        tick();
        check("tmo_req_done", 32'(arb_if.req_done), 32'b0001);
        check("tmo_idle", 32'(arb_if.busy), 32'd0);
        v = '{4'b0100, 32'h00510000, 3'd2, 8'h51, 4'b0000, 32'h00510000, 1'b0};
        do_xfer(v);
        check("err_sticky", 32'(arb_if.err), 32'd1);
`else
        check("err_tied_low", 32'(arb_if.err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
